// File: rtl/freelist_pkg.sv
// Shared rename-stage types and constants used by the physical-register free list.
//   SUPERSCALAR_WAYS : dispatch / retire width
//   N_PHYS_REG       : number of physical registers
//   N_ARCH_REG       : number of architectural registers
//   FREELIST_DEPTH   : tags held by the free list (N_PHYS_REG - N_ARCH_REG)
//   ZERO_REG         : tag of the hard-wired zero register; never freed nor committed
// Packets:
//   DISPATCH_FREELIST_PACKET : new_pr_en per way (tags consumed by dispatch)
//   ROB_FREELIST_PACKET      : valid / t_idx / told_idx of retiring instructions
//   FREELIST_DISPATCH_PACKET : offered tags t_idx plus per-way availability valid
package freelist_pkg;

  localparam int unsigned SUPERSCALAR_WAYS = 3;
  localparam int unsigned N_PHYS_REG       = 64;
  localparam int unsigned N_ARCH_REG       = 32;
  localparam int unsigned N_PHYS_REG_BITS  = $clog2(N_PHYS_REG);
  localparam int unsigned FREELIST_DEPTH   = N_PHYS_REG - N_ARCH_REG;

  localparam logic [N_PHYS_REG_BITS-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [SUPERSCALAR_WAYS-1:0] new_pr_en;
  } DISPATCH_FREELIST_PACKET;

  typedef struct packed {
    logic [SUPERSCALAR_WAYS-1:0]                      valid;
    logic [SUPERSCALAR_WAYS-1:0][N_PHYS_REG_BITS-1:0] t_idx;
    logic [SUPERSCALAR_WAYS-1:0][N_PHYS_REG_BITS-1:0] told_idx;
  } ROB_FREELIST_PACKET;

  typedef struct packed {
    logic [SUPERSCALAR_WAYS-1:0][N_PHYS_REG_BITS-1:0] t_idx;
    logic [SUPERSCALAR_WAYS-1:0]                      valid;
  } FREELIST_DISPATCH_PACKET;

endpackage

// File: rtl/freelist_prefix_count.sv
// Exclusive prefix population count over a per-way mask.
//   mask   : one bit per way
//   offset : offset[i] = number of set bits in mask[i-1:0]
//   total  : number of set bits in the whole mask
module freelist_prefix_count #(
  parameter int unsigned WAYS = 3,
  parameter int unsigned CNT_W = $clog2(WAYS + 1)
) (
  input  logic [WAYS-1:0]            mask,
  output logic [WAYS-1:0][CNT_W-1:0] offset,
  output logic [CNT_W-1:0]           total
);

  always_comb begin
    logic [CNT_W-1:0] acc;
    acc    = '0;
    offset = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      offset[i] = acc;
      acc       = acc + CNT_W'(mask[i]);
    end
    total = acc;
  end

endmodule

// File: rtl/freelist.sv
// Physical-register free list for the rename front end.
// Circular buffer of free tags with a speculative head (dispatch pops), a tail (retire
// pushes of told_idx) and a committed head (advanced by retiring t_idx). A branch flush
// snaps the speculative head back to the committed head, restoring the full committed set.
//   clock                 : clock, all state on the rising edge
//   reset                 : synchronous active-low reset
//   branch_flush_en       : mispredict recovery; dispatch pops ignored this cycle
//   dispatch_freelist_in  : new_pr_en, ways consuming a tag this cycle
//   rob_freelist_in       : retiring valid / t_idx / told_idx
//   freelist_dispatch_out : next free tags in order and their availability
//   free_count            : number of free entries
// WAYS must equal SUPERSCALAR_WAYS (packet width); N_PR - N_AR must be a power of two.
module freelist
  import freelist_pkg::*;
#(
  parameter int unsigned WAYS = SUPERSCALAR_WAYS,
  parameter int unsigned N_PR = N_PHYS_REG,
  parameter int unsigned N_AR = N_ARCH_REG,
  parameter int unsigned DEPTH = N_PR - N_AR,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    branch_flush_en,
  input  DISPATCH_FREELIST_PACKET dispatch_freelist_in,
  input  ROB_FREELIST_PACKET      rob_freelist_in,
  output FREELIST_DISPATCH_PACKET freelist_dispatch_out,
  output logic [CNT_W-1:0]        free_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OFF_W = $clog2(WAYS + 1);
  localparam int unsigned TAG_W = N_PHYS_REG_BITS;

  logic [TAG_W-1:0] fl_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] retire_head_q, retire_head_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [WAYS-1:0]            push_mask, commit_mask;
  logic [WAYS-1:0][OFF_W-1:0] push_off;
  logic [WAYS-1:0][OFF_W-1:0] unused_commit_off;
  logic [OFF_W-1:0]           npush, ncommit, npop;

  // Retire filtering: the zero register is never returned nor counted as committed.
  always_comb begin
    push_mask   = '0;
    commit_mask = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      push_mask[i]   = rob_freelist_in.valid[i] && (rob_freelist_in.told_idx[i] != ZERO_REG);
      commit_mask[i] = rob_freelist_in.valid[i] && (rob_freelist_in.t_idx[i] != ZERO_REG);
    end
  end

  freelist_prefix_count #(
    .WAYS (WAYS),
    .CNT_W(OFF_W)
  ) u_push_count (
    .mask  (push_mask),
    .offset(push_off),
    .total (npush)
  );

  freelist_prefix_count #(
    .WAYS (WAYS),
    .CNT_W(OFF_W)
  ) u_commit_count (
    .mask  (commit_mask),
    .offset(unused_commit_off),
    .total (ncommit)
  );

  // Dispatch packs its allocations, so only the number of consumed tags matters here.
  assign npop = OFF_W'($countones(dispatch_freelist_in.new_pr_en));

  always_comb begin
    freelist_dispatch_out = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      freelist_dispatch_out.t_idx[i] = fl_q[head_q + PTR_W'(i)];
      freelist_dispatch_out.valid[i] = CNT_W'(i) < count_q;
    end
  end

  assign free_count = count_q;

  always_comb begin
    tail_d        = tail_q + PTR_W'(npush);
    retire_head_d = retire_head_q + PTR_W'(ncommit);
    if (branch_flush_en) begin
      // Committed set always holds DEPTH tags, so recovery refills the list completely.
      head_d  = retire_head_d;
      count_d = CNT_W'(DEPTH);
    end else begin
      head_d  = head_q + PTR_W'(npop);
      count_d = count_q - CNT_W'(npop) + CNT_W'(npush);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fl_q[i] <= TAG_W'(N_AR + i);
      end
      head_q        <= '0;
      tail_q        <= '0;
      retire_head_q <= '0;
      count_q       <= CNT_W'(DEPTH);
    end else begin
      for (int unsigned i = 0; i < WAYS; i++) begin
        if (push_mask[i]) begin
          fl_q[tail_q + PTR_W'(push_off[i])] <= rob_freelist_in.told_idx[i];
        end
      end
      head_q        <= head_d;
      tail_q        <= tail_d;
      retire_head_q <= retire_head_d;
      count_q       <= count_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (reset && !branch_flush_en) begin
      assert (CNT_W'(npop) <= count_q);
      assert (({1'b0, count_q} + (CNT_W + 1)'(npush)) <=
              ((CNT_W + 1)'(DEPTH) + (CNT_W + 1)'(npop)));
    end
  end
`endif

endmodule

// File: tb/tb_freelist.sv
// Self-checking bench for freelist: directed vectors with hand-computed expectations,
// followed by legal random traffic checked against a queue model of the free list.
module tb_freelist;
  import freelist_pkg::*;

  localparam int DEPTH = FREELIST_DEPTH;

  logic                    clock = 1'b0;
  logic                    reset = 1'b0;
  logic                    branch_flush_en;
  DISPATCH_FREELIST_PACKET dispatch_freelist_in;
  ROB_FREELIST_PACKET      rob_freelist_in;
  FREELIST_DISPATCH_PACKET freelist_dispatch_out;
  logic [5:0]              free_count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int t;
    int told;
    int r;
  } rob_e_t;

  rob_e_t rob[$];
  int     fq[$];
  int     spec_off;
  int     map_spec[32];
  int     map_arch[32];

  freelist dut (
    .clock                (clock),
    .reset                (reset),
    .branch_flush_en      (branch_flush_en),
    .dispatch_freelist_in (dispatch_freelist_in),
    .rob_freelist_in      (rob_freelist_in),
    .freelist_dispatch_out(freelist_dispatch_out),
    .free_count           (free_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    branch_flush_en      = 1'b0;
    dispatch_freelist_in = '0;
    rob_freelist_in      = '0;
  endtask

  // A negative expected tag skips that tag comparison.
  task automatic expect_out(input string tag, input int t0, input int t1, input int t2,
                            input int v, input int cnt);
    if (t0 >= 0) check({tag, ".t0"}, 32'(freelist_dispatch_out.t_idx[0]), t0);
    if (t1 >= 0) check({tag, ".t1"}, 32'(freelist_dispatch_out.t_idx[1]), t1);
    if (t2 >= 0) check({tag, ".t2"}, 32'(freelist_dispatch_out.t_idx[2]), t2);
    check({tag, ".valid"}, 32'(freelist_dispatch_out.valid), v);
    check({tag, ".count"}, 32'(free_count), cnt);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    step();
    reset = 1'b1;
  endtask

  task automatic model_init();
    rob.delete();
    fq.delete();
    for (int i = 0; i < DEPTH; i++) fq.push_back(32 + i);
    spec_off = 0;
    for (int r = 0; r < 32; r++) begin
      map_spec[r] = r;
      map_arch[r] = r;
    end
  endtask

  task automatic set_retire(input int w, input int t, input int told);
    rob_freelist_in.valid[w]    = 1'b1;
    rob_freelist_in.t_idx[w]    = 6'(t);
    rob_freelist_in.told_idx[w] = 6'(told);
  endtask

  initial begin
    idle_inputs();

    // Reset values, then stable with no traffic.
    do_reset();
    expect_out("reset", 32, 33, 34, 7, 32);
    step();
    expect_out("idle", 32, 33, 34, 7, 32);

    // Sparse allocation consumes two tags.
    dispatch_freelist_in.new_pr_en = 3'b101;
    step();
    idle_inputs();
    expect_out("pop101", 34, 35, 36, 7, 30);

    // Pop 3 with retire pushing 5 and 9 (zero told skipped); flush exposes tail slots 0,1.
    do_reset();
    dispatch_freelist_in.new_pr_en = 3'b111;
    set_retire(0, 0, 5);
    set_retire(1, 0, 0);
    set_retire(2, 0, 9);
    step();
    idle_inputs();
    expect_out("retire", 35, 36, 37, 7, 31);
    branch_flush_en = 1'b1;
    step();
    idle_inputs();
    expect_out("retire_flush", 5, 9, 34, 7, 32);

    // Drain all 32 tags over 11 cycles, wrapping head at the end.
    do_reset();
    for (int c = 0; c < 11; c++) begin
      int h;
      int cnt;
      dispatch_freelist_in.new_pr_en = (c < 10) ? 3'b111 : 3'b011;
      step();
      idle_inputs();
      h   = (c < 10) ? 3 * (c + 1) : 0;
      cnt = (c < 10) ? 29 - 3 * c : 0;
      expect_out($sformatf("drain%0d", c), 32 + (h % 32), 32 + ((h + 1) % 32),
                 32 + ((h + 2) % 32), (cnt >= 3) ? 7 : ((cnt == 2) ? 3 : 0), cnt);
    end
    // Pushes into an empty list become visible only on the following cycle.
    set_retire(0, 0, 7);
    set_retire(1, 0, 8);
    check("empty.valid_same_cycle", 32'(freelist_dispatch_out.valid), 0);
    step();
    idle_inputs();
    expect_out("refill", 7, 8, 34, 3, 2);

    // Flush with two commits (one retiring way has t_idx zero); dispatch is ignored.
    do_reset();
    dispatch_freelist_in.new_pr_en = 3'b111;
    step();
    step();
    idle_inputs();
    expect_out("pop6", 38, 39, 40, 7, 26);
    branch_flush_en                = 1'b1;
    dispatch_freelist_in.new_pr_en = 3'b111;
    set_retire(0, 32, 1);
    set_retire(1, 0, 0);
    set_retire(2, 33, 2);
    step();
    idle_inputs();
    expect_out("flush", 34, 35, 36, 7, 32);
    dispatch_freelist_in.new_pr_en = 3'b111;
    step();
    idle_inputs();
    expect_out("post_flush", 37, 38, 39, 7, 29);

    // Random legal traffic against a queue model.
    do_reset();
    model_init();
    for (int cyc = 0; cyc < 100; cyc++) begin
      int         count_m;
      int         ev;
      int         nret;
      int         lim;
      int         npop;
      int         dtag[3];
      logic       flush;
      logic [2:0] m;

      if (cyc == 50) begin
        do_reset();
        expect_out("mid_reset", 32, 33, 34, 7, 32);
        model_init();
      end

      count_m = fq.size() - spec_off;
      ev      = (count_m >= 3) ? 7 : ((count_m == 2) ? 3 : ((count_m == 1) ? 1 : 0));
      check($sformatf("rnd%0d.count", cyc), 32'(free_count), count_m);
      check($sformatf("rnd%0d.valid", cyc), 32'(freelist_dispatch_out.valid), ev);
      for (int i = 0; i < 3; i++) begin
        if (i < count_m) begin
          int tag;
          int hit;
          tag = int'(freelist_dispatch_out.t_idx[i]);
          check($sformatf("rnd%0d.t%0d", cyc, i), 32'(tag), fq[spec_off + i]);
          hit = 0;
          for (int r = 1; r < 32; r++) if (map_spec[r] == tag) hit = 1;
          foreach (rob[k]) if (rob[k].told == tag) hit = 1;
          check($sformatf("rnd%0d.live%0d", cyc, i), 32'(hit), 0);
        end
      end

      flush = ($urandom_range(0, 15) == 0);
      nret  = $urandom_range(0, (rob.size() < 3) ? rob.size() : 3);
      for (int i = 0; i < nret; i++) set_retire(i, rob[i].t, rob[i].told);
      lim = (count_m < 3) ? count_m : 3;
      do m = 3'($urandom_range(0, 7)); while ($countones(m) > lim);
      dispatch_freelist_in.new_pr_en = m;
      branch_flush_en                = flush;

      npop = 0;
      for (int k = 0; k < 3; k++) begin
        if (m[k]) begin
          dtag[npop] = fq[spec_off + npop];
          npop++;
        end
      end

      step();
      idle_inputs();

      for (int i = 0; i < nret; i++) begin
        rob_e_t e;
        e = rob.pop_front();
        map_arch[e.r] = e.t;
        fq.push_back(e.told);
        void'(fq.pop_front());
        spec_off--;
      end
      if (flush) begin
        rob.delete();
        map_spec = map_arch;
        spec_off = 0;
      end else begin
        for (int j = 0; j < npop; j++) begin
          int r;
          r = $urandom_range(1, 31);
          rob.push_back('{t: dtag[j], told: map_spec[r], r: r});
          map_spec[r] = dtag[j];
        end
        spec_off += npop;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/freelist.md
# freelist

Physical-register free list for the renaming front end. Offers up to `SUPERSCALAR_WAYS` free physical-register tags to dispatch each cycle, consumes the tags dispatch allocates, and reclaims each retiring instruction's old tag (`told_idx`) from the ROB. On a branch flush it rolls back to the architecturally committed free set. Sits between dispatch, the ROB retire port and the map table's recovery logic.

## Interface
- `WAYS`, default `` `SUPERSCALAR_WAYS `` (3): dispatch/retire width.
- `N_PR`, default `` `N_PHYS_REG `` (64): number of physical registers.
- `N_AR`, default `` `N_ARCH_REG `` (32): number of architectural registers.
- `DEPTH` (local): `N_PR - N_AR`. Must be a power of two.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `branch_flush_en`  in  1  mispredict recovery.
- `dispatch_freelist_in`  in  `DISPATCH_FREELIST_PACKET`  `new_pr_en[WAYS]`: one bit per way that consumes a tag.
- `rob_freelist_in`  in  `ROB_FREELIST_PACKET`  `valid[WAYS]`, `t_idx[WAYS]`, `told_idx[WAYS]` of retiring instructions.
- `freelist_dispatch_out`  out  `FREELIST_DISPATCH_PACKET`  `t_idx[WAYS]`: next free tags in order. `valid[WAYS]`: tag i is available.
- `free_count`  out  `$clog2(DEPTH)+1`  entries currently free.

## Operation
- State:
  - circular array `fl[DEPTH]` of `N_PHYS_REG_BITS` tags;
  - `head`, `tail`, `retire_head` (each `$clog2(DEPTH)` bits, natural wrap);
  - `count`.
- Peek (combinational from registered state):
  - `t_idx[i] = fl[head+i]`.
  - `valid[i] = (i < count)`.
  - Tags pushed this cycle are not visible until the next cycle.
- Pop: `npop` = popcount(`new_pr_en`), so `head += npop`.
  - Dispatch packs allocations, so way k's tag is `t_idx[number of enabled ways below k]`. The freelist only counts.
  - Requires `npop <= count`. A violation is an assertion failure and the state is undefined.
- Push: for each retiring way i with `valid[i]` and `told_idx[i] != ZERO_REG`:
  - write `told_idx[i]` to `fl[tail + (number of such earlier ways)]`;
  - `tail += npush`.
- Committed pointer: `retire_head += ncommit`, where `ncommit` = number of retiring ways with `valid` and `t_idx != ZERO_REG`.
- `count_next = count - npop + npush`. `count_next > DEPTH` is an assertion failure.
- Flush (`branch_flush_en`):
  - `new_pr_en` is ignored;
  - that cycle's retire push and commit are still applied;
  - then `head <= retire_head_next`, `count <= DEPTH`;
  - `tail` is unchanged.
  - Invariant: the committed free set always holds exactly `DEPTH` tags.

## Timing
- Zero-latency tag offer. Pop, push and flush all take effect at the next rising edge.
- Reset (when `reset` == 0 at the edge):
  - `fl[i] = N_AR + i`;
  - `head = tail = retire_head = 0`;
  - `count = DEPTH`;
  - outputs after reset: `t_idx[i] = N_AR + i`, all `valid` = 1, `free_count = DEPTH`.
- Reset overrides flush, pop and push.
- Reset asserted mid-operation discards all in-flight state.
- Simultaneous pop and push in one cycle: both apply. When the list is empty (`count == 0`), same-cycle pushes are not poppable until the next cycle.
- Wrap-around: all pointer and offset arithmetic is modulo `DEPTH`, with no extra wrap bit. `count` alone distinguishes full from empty.
- Full (`count == DEPTH`): pushes are impossible by the invariant.
- Empty (`count == 0`): all `valid` = 0. Dispatch must stall.

## Structure
- Shared package additions:
  - `FREELIST_DISPATCH_PACKET` (extend with `valid[WAYS]`);
  - `ROB_FREELIST_PACKET`;
  - `FREELIST_DEPTH` constant.
- Existing: `DISPATCH_FREELIST_PACKET`, `ZERO_REG`, `N_PHYS_REG_BITS`.
- One sub-module: `freelist_prefix_count`. It takes a `WAYS`-bit mask and returns per-way prefix offsets plus the total. It is instantiated twice: for push offsets and for `ncommit`. `npop` uses the total only.

## Test plan
- Reset, then no traffic:
  - `t_idx` = {32,33,34}, `valid` = 3'b111, `free_count` = 32.
- `new_pr_en` = 3'b101 for one cycle:
  - next cycle `t_idx` = {34,35,36}, `free_count` = 30.
- Retire `told_idx` = {5,0,9} with `valid` = 3'b111, alongside a pop of 3:
  - 5 and 9 are written at `tail` slots 0 and 1, so `tail` = 2;
  - `free_count` goes from 32 to 31 (−3 + 2).
- Drain 32 tags over 11 cycles:
  - `valid` goes 3'b111 down to 3'b011 (count 2) and then 3'b000;
  - `free_count` = 0.
- Pop 6 tags (`head` = 6), then `branch_flush_en` in the same cycle as a retire committing 2:
  - next cycle `head` = 2, `free_count` = 32, `t_idx` = {34,35,36};
  - the `new_pr_en` presented during the flush is ignored.
- Run 100 cycles of random legal traffic:
  - `head` wraps past 31 several times;
  - check against a queue model;
  - no tag is ever offered twice while live;
  - `reset` low mid-run restores the reset values on the next edge.
